// File: rtl/round_key_xor_if.sv
// Bus bundle for round_key_xor: key-bank write port plus the data-in / result-out
// valid/ready stream.
interface round_key_xor_if #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned NUM_ROUNDS = 10
);
  localparam int unsigned IDX_W = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned NKEYS = NUM_ROUNDS + 1;

  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_idx;
  logic [DATA_W-1:0] key_wr_data;
  logic              key_clear;
  logic [NKEYS-1:0]  key_ready_mask;

  logic              data_valid_in;
  logic              data_ready_out;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  round_idx_in;

  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic [IDX_W-1:0]  round_idx_out;
  logic              err_out;

  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_data, key_clear,
    input  data_valid_in, data_in, round_idx_in, ready_in,
    output key_ready_mask, data_ready_out, valid_out, data_out, round_idx_out, err_out
  );

  modport master (
    output key_wr_en, key_wr_idx, key_wr_data, key_clear,
    output data_valid_in, data_in, round_idx_in, ready_in,
    input  key_ready_mask, data_ready_out, valid_out, data_out, round_idx_out, err_out
  );
endinterface

// File: rtl/round_key_xor.sv
// Round-key bank with per-index valid bits; XORs each accepted state word with the
// selected key into a registered, backpressured output slot.
module round_key_xor #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic            clk,
  input logic            reset,
  round_key_xor_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned NKEYS = NUM_ROUNDS + 1;

  logic [DATA_W-1:0] bank_q [NKEYS];
  logic [NKEYS-1:0]  mask_q, mask_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] key_sel;
  logic              key_loaded;
  logic              in_range;
  logic              key_ok;
  logic              slot_free;
  logic              ready;
  logic              accept;

  // Key lookup by compare loop so out-of-range indices never address the bank.
  always_comb begin
    key_sel    = '0;
    key_loaded = 1'b0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (bus.round_idx_in == IDX_W'(i)) begin
        key_sel    = bank_q[i];
        key_loaded = mask_q[i];
      end
    end
  end

  assign in_range  = bus.round_idx_in <= IDX_W'(NUM_ROUNDS);
  assign key_ok    = key_loaded || !in_range;
  assign slot_free = !valid_q || bus.ready_in;
  assign ready     = slot_free && key_ok && !reset;
  assign accept    = bus.data_valid_in && ready;

  // Clear drops every bit; a same-cycle write re-sets its own index.
  always_comb begin
    mask_d = bus.key_clear ? '0 : mask_q;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (bus.key_wr_en && bus.key_wr_idx == IDX_W'(i)) mask_d[i] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = bus.data_in ^ (in_range ? key_sel : '0);
      idx_d   = bus.round_idx_in;
      err_d   = !in_range;
    end else if (bus.ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NKEYS; i++) bank_q[i] <= '0;
    end else begin
      mask_q  <= mask_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (bus.key_wr_en && bus.key_wr_idx == IDX_W'(i)) bank_q[i] <= bus.key_wr_data;
      end
    end
  end

  assign bus.key_ready_mask = mask_q;
  assign bus.data_ready_out = ready;
  assign bus.valid_out      = valid_q;
  assign bus.data_out       = data_q;
  assign bus.round_idx_out  = idx_q;
  assign bus.err_out        = err_q;
endmodule

// File: tb/tb_round_key_xor.sv
// Directed bench for round_key_xor: vector table plus hand sequences for stall,
// read-before-write, streaming backpressure and mid-stream reset.
module tb_round_key_xor;
  localparam int unsigned DW = 128;
  localparam int unsigned NR = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  round_key_xor_if #(.DATA_W(DW), .NUM_ROUNDS(NR)) bus ();
  round_key_xor #(.DATA_W(DW), .NUM_ROUNDS(NR)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] din;
    logic [127:0] dout;
    logic         err;
  } vec_t;

  vec_t         vecs [8];
  logic [127:0] kmodel [11];
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] idx, input logic [127:0] d);
    bus.key_wr_en   = 1'b1;
    bus.key_wr_idx  = idx;
    bus.key_wr_data = d;
    cyc();
    bus.key_wr_en = 1'b0;
    if (idx <= 4'd10) kmodel[idx] = d;
  endtask

  // Present a word, wait (bounded) for ready, let it be accepted, then drop valid.
  task automatic send(input logic [3:0] idx, input logic [127:0] d);
    bit ok;
    ok = 1'b0;
    bus.data_valid_in = 1'b1;
    bus.round_idx_in  = idx;
    bus.data_in       = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (bus.data_ready_out) ok = 1'b1;
      else cyc();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: idx %0d never accepted", idx);
    end
    cyc();
    bus.data_valid_in = 1'b0;
  endtask

  function automatic logic [127:0] stream_din(input int k);
    return {16{8'(8'h30 + k)}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, recv;
    bit acc, rel;

    vecs[0] = '{4'd0,  128'h00112233445566778899aabbccddeeff, 128'h00102030405060708090a0b0c0d0e0f0, 1'b0};
    vecs[1] = '{4'd1,  128'h0,                                 {16{8'h11}},                          1'b0};
    vecs[2] = '{4'd5,  {16{8'hff}},                            {16{8'haa}},                          1'b0};
    vecs[3] = '{4'd10, {16{8'haa}},                            128'h0,                               1'b0};
    vecs[4] = '{4'd3,  {16{8'h0f}},                            {16{8'h3c}},                          1'b0};
    vecs[5] = '{4'd15, {16{8'ha5}},                            {16{8'ha5}},                          1'b1};
    vecs[6] = '{4'd11, 128'h123456789abcdef00fedcba987654321, 128'h123456789abcdef00fedcba987654321, 1'b1};
    vecs[7] = '{4'd7,  {16{8'h77}},                            128'h0,                               1'b0};

    for (int i = 0; i < 11; i++) kmodel[i] = '0;
    reset             = 1'b1;
    bus.key_wr_en     = 1'b0;
    bus.key_wr_idx    = '0;
    bus.key_wr_data   = '0;
    bus.key_clear     = 1'b0;
    bus.data_valid_in = 1'b1;
    bus.round_idx_in  = 4'd15;
    bus.data_in       = '0;
    bus.ready_in      = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 128'(bus.valid_out), 128'h0);
    chk("rst_data", bus.data_out, 128'h0);
    chk("rst_idx", 128'(bus.round_idx_out), 128'h0);
    chk("rst_err", 128'(bus.err_out), 128'h0);
    chk("rst_mask", 128'(bus.key_ready_mask), 128'h0);
    chk("rst_ready", 128'(bus.data_ready_out), 128'h0);
    bus.data_valid_in = 1'b0;
    reset = 1'b0;
    cyc();

    // Word for an unloaded key stalls until its key arrives.
    bus.data_valid_in = 1'b1;
    bus.round_idx_in  = 4'd3;
    bus.data_in       = 128'h0123456789abcdeffedcba9876543210;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready", 128'(bus.data_ready_out), 128'h0);
      cyc();
    end
    bus.key_wr_en   = 1'b1;
    bus.key_wr_idx  = 4'd3;
    bus.key_wr_data = {16{8'hff}};
    #1;
    chk("stall_ready_wrcyc", 128'(bus.data_ready_out), 128'h0);
    cyc();
    bus.key_wr_en = 1'b0;
    kmodel[3] = {16{8'hff}};
    #1;
    chk("stall_ready_after", 128'(bus.data_ready_out), 128'h1);
    cyc();
    bus.data_valid_in = 1'b0;
    chk("stall_valid", 128'(bus.valid_out), 128'h1);
    chk("stall_data", bus.data_out, 128'hfedcba98765432100123456789abcdef);
    chk("stall_idx", 128'(bus.round_idx_out), 128'h3);
    chk("stall_err", 128'(bus.err_out), 128'h0);

    // Clear and write in the same cycle.
    bus.key_clear = 1'b1;
    wr_key(4'd4, {16{8'h44}});
    bus.key_clear = 1'b0;
    chk("clear_wr_mask", 128'(bus.key_ready_mask), 128'h010);

    send(4'd15, {16{8'ha5}});
    chk("oor_valid", 128'(bus.valid_out), 128'h1);
    chk("oor_data", bus.data_out, {16{8'ha5}});
    chk("oor_err", 128'(bus.err_out), 128'h1);
    chk("oor_idx", 128'(bus.round_idx_out), 128'hf);

    wr_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 1; i <= 10; i++) wr_key(4'(i), {16{8'(i * 17)}});
    chk("load_mask", 128'(bus.key_ready_mask), 128'h7ff);

    foreach (vecs[i]) begin
      send(vecs[i].idx, vecs[i].din);
      chk("vec_valid", 128'(bus.valid_out), 128'h1);
      chk("vec_data", bus.data_out, vecs[i].dout);
      chk("vec_idx", 128'(bus.round_idx_out), 128'(vecs[i].idx));
      chk("vec_err", 128'(bus.err_out), 128'(vecs[i].err));
    end

    // Same-cycle key write does not affect the word accepted that cycle.
    bus.data_valid_in = 1'b1;
    bus.round_idx_in  = 4'd2;
    bus.data_in       = '0;
    bus.key_wr_en     = 1'b1;
    bus.key_wr_idx    = 4'd2;
    bus.key_wr_data   = {16{8'h5c}};
    #1;
    chk("rbw_ready", 128'(bus.data_ready_out), 128'h1);
    cyc();
    bus.data_valid_in = 1'b0;
    bus.key_wr_en     = 1'b0;
    kmodel[2] = {16{8'h5c}};
    chk("rbw_old_key", bus.data_out, {16{8'h22}});
    send(4'd2, 128'h0);
    chk("rbw_new_key", bus.data_out, {16{8'h5c}});

    // Drain, then stream 11 words with downstream stall on cycles 3..5.
    cyc();
    chk("drain_valid", 128'(bus.valid_out), 128'h0);
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40; c++) begin
      bus.ready_in      = !(c >= 3 && c <= 5);
      bus.data_valid_in = sent < 11;
      bus.round_idx_in  = 4'(sent);
      bus.data_in       = stream_din(sent);
      #1;
      if (bus.valid_out) begin
        if (recv < 11) begin
          chk("stream_data", bus.data_out, stream_din(recv) ^ kmodel[recv]);
          chk("stream_idx", 128'(bus.round_idx_out), 128'(recv));
        end else begin
          chk("stream_extra", 128'(bus.valid_out), 128'h0);
        end
      end
      if (c == 4) chk("stream_stall_valid", 128'(bus.valid_out), 128'h1);
      rel = bus.valid_out && bus.ready_in;
      acc = bus.data_valid_in && bus.data_ready_out;
      cyc();
      if (rel) recv++;
      if (acc) sent++;
    end
    bus.data_valid_in = 1'b0;
    chk("stream_sent", 128'(sent), 128'd11);
    chk("stream_recv", 128'(recv), 128'd11);
    chk("stream_idle", 128'(bus.valid_out), 128'h0);

    // Reset while a result is held by downstream backpressure.
    bus.ready_in = 1'b0;
    send(4'd1, {16{8'h0f}});
    chk("prersv_valid", 128'(bus.valid_out), 128'h1);
    reset = 1'b1;
    cyc();
    chk("mrst_valid", 128'(bus.valid_out), 128'h0);
    chk("mrst_data", bus.data_out, 128'h0);
    chk("mrst_idx", 128'(bus.round_idx_out), 128'h0);
    chk("mrst_err", 128'(bus.err_out), 128'h0);
    chk("mrst_mask", 128'(bus.key_ready_mask), 128'h0);
    reset = 1'b0;
    bus.ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mrst_no_release", 128'(bus.valid_out), 128'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
